// File: rtl/uart_tx.sv
// uart_tx: byte-wide serial transmitter fed by the print formatter.
//
// Frame: start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1).
// Each bit is held for DIV = CLK_FREQ/BAUD clocks.
//
// Handshake: a byte is taken on a rising clk edge where vld_tx = 1 and the
// registered rdy_tx = 1. rdy_tx then stays low for the whole frame and rises
// on the edge that ends the stop bit. Because acceptance looks at the
// registered rdy_tx, the earliest next acceptance is one clock after rdy_tx
// rises. d_tx/vld_tx are ignored while rdy_tx = 0.
//
// Ports:
//   clk     system clock, rising edge
//   rstn    synchronous active-low reset; aborts any frame in progress
//   d_tx    byte to send, valid while vld_tx = 1
//   vld_tx  producer has a byte on d_tx
//   rdy_tx  1 = idle and able to accept, 0 = frame in progress (registered)
//   txd     serial line, idle high (registered)
//
// Parameters:
//   CLK_FREQ  clock frequency in Hz
//   BAUD      line rate in bit/s (DIV must come out >= 2)
//   PARITY    0 = none, 1 = even, 2 = odd

module uart_tx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int PARITY   = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] d_tx,
  input  logic       vld_tx,
  output logic       rdy_tx,
  output logic       txd
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   baud_cnt, baud_n;
  logic [2:0]      bit_idx, idx_n;
  logic [7:0]      shift, shift_n;
  logic            par_bit, par_n;
  logic            txd_n, rdy_n;
  logic            bit_end;

  // Last clock of the current serial bit.
  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      txd      <= 1'b1;
      rdy_tx   <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= idx_n;
      shift    <= shift_n;
      par_bit  <= par_n;
      txd      <= txd_n;
      rdy_tx   <= rdy_n;
    end
  end

  // Next-state logic. txd_n/rdy_n are the values the line and ready flag
  // take on the next edge, so every output transition is computed one
  // step ahead and lands exactly on the bit boundary.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    idx_n   = bit_idx;
    shift_n = shift;
    par_n   = par_bit;
    txd_n   = txd;
    rdy_n   = rdy_tx;

    case (state)
      S_IDLE: begin
        txd_n  = 1'b1;
        rdy_n  = 1'b1;
        baud_n = '0;
        if (vld_tx && rdy_tx) begin
          shift_n = d_tx;
          par_n   = (PARITY == 2) ? ~(^d_tx) : (^d_tx);
          rdy_n   = 1'b0;
          txd_n   = 1'b0;
          state_n = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          baud_n  = '0;
          idx_n   = '0;
          txd_n   = shift[0];
          state_n = S_DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            if (PARITY != 0) begin
              txd_n   = par_bit;
              state_n = S_PARITY;
            end else begin
              txd_n   = 1'b1;
              state_n = S_STOP;
            end
          end else begin
            idx_n = bit_idx + 3'd1;
            txd_n = shift[bit_idx + 3'd1];
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          baud_n  = '0;
          txd_n   = 1'b1;
          state_n = S_STOP;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          baud_n  = '0;
          rdy_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      default: begin
        txd_n   = 1'b1;
        rdy_n   = 1'b1;
        baud_n  = '0;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
